// File: rtl/multilatch_seq_pkg.sv
// Shared types and constants for the multi-output latch sequencer.
package multilatch_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    LAT,
    DRV1,
    DRV2,
    TURN
  } state_e;

  localparam int unsigned BUS1 = 0;
  localparam int unsigned BUS2 = 1;

  // Counter width able to hold 0..n, never narrower than one bit.
  function automatic int unsigned cnt_w(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/multilatch_rr_arb.sv
// Two-way round-robin arbiter; the pointer moves past the bus that was granted.
module multilatch_rr_arb
  import multilatch_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] i_req,
  input  logic       i_take,
  output logic [1:0] o_gnt
);

  logic r_ptr;  // 0: bus1 wins a tie, 1: bus2 wins a tie

  always_comb begin
    o_gnt = '0;
    if (i_req[BUS1] && i_req[BUS2]) begin
      o_gnt[r_ptr] = 1'b1;
    end else begin
      o_gnt = i_req;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= 1'b0;
    end else if (i_take && (|o_gnt)) begin
      r_ptr <= o_gnt[BUS1];
    end
  end

endmodule

// File: rtl/multilatch_seq.sv
// Sequencer driving clear/latch/oe1/oe2 of a shared 12-bit latch for one loader and two readers.
module multilatch_seq
  import multilatch_seq_pkg::*;
#(
  parameter int unsigned OE_CYCLES   = 2,
  parameter int unsigned TURN_CYCLES = 1,
  parameter bit          CLEAR_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ld_req,
  output logic       ld_ack,
  input  logic [1:0] rd_req,
  output logic [1:0] rd_ack,
  output logic       lat_clear,
  output logic       lat_latch,
  output logic       lat_oe1,
  output logic       lat_oe2,
  output logic       busy,
  output logic       valid
);

  localparam int unsigned OE_W = cnt_w(OE_CYCLES);
  localparam int unsigned TN_W = cnt_w(TURN_CYCLES);

  state_e          r_state;
  state_e          w_next;
  logic            r_ld_pend;
  logic [1:0]      r_rd_pend;
  logic            r_valid;
  logic [OE_W-1:0] r_oe_cnt;
  logic [TN_W-1:0] r_turn_cnt;

  logic            w_oe_last;
  logic            w_turn_last;
  logic            w_ld_ack;
  logic [1:0]      w_rd_ack;
  logic            w_ld_next;
  logic [1:0]      w_rd_next;
  logic            w_dispatch;
  logic            w_take;
  logic [1:0]      w_gnt;

  assign w_oe_last   = (r_oe_cnt == OE_W'(OE_CYCLES - 1));
  assign w_turn_last = (r_turn_cnt == TN_W'(TURN_CYCLES - 1));

  assign w_ld_ack       = (r_state == LAT);
  assign w_rd_ack[BUS1] = (r_state == DRV1) && w_oe_last;
  assign w_rd_ack[BUS2] = (r_state == DRV2) && w_oe_last;

  // Pending view after this cycle's acks retire and new pulses are merged in.
  assign w_ld_next = (r_ld_pend & ~w_ld_ack) | ld_req;
  assign w_rd_next = (r_rd_pend & ~w_rd_ack) | rd_req;

  assign w_take = w_dispatch && !w_ld_next && (|w_rd_next);

  multilatch_rr_arb u_arb (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_req  (w_rd_next),
    .i_take (w_take),
    .o_gnt  (w_gnt)
  );

  // Leaving LAT or the last drive/turnaround cycle makes the IDLE decision
  // directly, so back-to-back work spends no cycle in IDLE.
  always_comb begin
    w_dispatch = 1'b0;
    w_next     = r_state;
    unique case (r_state)
      IDLE: w_dispatch = 1'b1;
      CLR:  w_next = LAT;
      LAT:  w_dispatch = 1'b1;
      DRV1, DRV2: begin
        if (w_oe_last) begin
          if (TURN_CYCLES == 0) w_dispatch = 1'b1;
          else                  w_next     = TURN;
        end
      end
      TURN: w_dispatch = w_turn_last;
      default: w_next = IDLE;
    endcase

    if (w_dispatch) begin
      if (w_ld_next)            w_next = CLEAR_FIRST ? CLR : LAT;
      else if (w_gnt[BUS1])     w_next = DRV1;
      else if (w_gnt[BUS2])     w_next = DRV2;
      else                      w_next = IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_ld_pend  <= 1'b0;
      r_rd_pend  <= '0;
      r_valid    <= 1'b0;
      r_oe_cnt   <= '0;
      r_turn_cnt <= '0;
    end else begin
      r_state   <= w_next;
      r_ld_pend <= w_ld_next;
      r_rd_pend <= w_rd_next;
      if (r_state == LAT) begin
        r_valid <= 1'b1;
      end
      if (((r_state == DRV1) || (r_state == DRV2)) && !w_oe_last) begin
        r_oe_cnt <= r_oe_cnt + 1'b1;
      end else begin
        r_oe_cnt <= '0;
      end
      if ((r_state == TURN) && !w_turn_last) begin
        r_turn_cnt <= r_turn_cnt + 1'b1;
      end else begin
        r_turn_cnt <= '0;
      end
    end
  end

  // Controls decode from state alone so reset clears them without a clock.
  always_comb begin
    ld_ack    = w_ld_ack;
    rd_ack    = w_rd_ack;
    lat_clear = (r_state == CLR);
    lat_latch = (r_state == LAT);
    lat_oe1   = (r_state == DRV1);
    lat_oe2   = (r_state == DRV2);
    busy      = (r_state != IDLE);
    valid     = r_valid;
  end

endmodule

// File: tb/tb_multilatch_seq.sv
// Scoreboard bench for multilatch_seq: expected control vectors are queued with their cycle.
module tb_multilatch_seq;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ld_req = 1'b0;
  logic [1:0] rd_req = '0;
  logic       ld_ack, lat_clear, lat_latch, lat_oe1, lat_oe2, busy, valid;
  logic [1:0] rd_ack;

  logic       n_ld_req = 1'b0;
  logic [1:0] n_rd_req = '0;
  logic       n_ld_ack, n_lat_clear, n_lat_latch, n_lat_oe1, n_lat_oe2, n_busy, n_valid;
  logic [1:0] n_rd_ack;

  always #5 clk = ~clk;

  multilatch_seq u_dut (
    .clk(clk), .rst_n(rst_n), .ld_req(ld_req), .ld_ack(ld_ack),
    .rd_req(rd_req), .rd_ack(rd_ack), .lat_clear(lat_clear),
    .lat_latch(lat_latch), .lat_oe1(lat_oe1), .lat_oe2(lat_oe2),
    .busy(busy), .valid(valid)
  );

  multilatch_seq #(.OE_CYCLES(1), .TURN_CYCLES(0), .CLEAR_FIRST(1'b0)) u_dut_nc (
    .clk(clk), .rst_n(rst_n), .ld_req(n_ld_req), .ld_ack(n_ld_ack),
    .rd_req(n_rd_req), .rd_ack(n_rd_ack), .lat_clear(n_lat_clear),
    .lat_latch(n_lat_latch), .lat_oe1(n_lat_oe1), .lat_oe2(n_lat_oe2),
    .busy(n_busy), .valid(n_valid)
  );

  // {ld_ack, rd_ack[1:0], clear, latch, oe1, oe2}
  localparam logic [6:0] V_CLR  = 7'b000_1000;
  localparam logic [6:0] V_LAT  = 7'b100_0100;
  localparam logic [6:0] V_OE1  = 7'b000_0010;
  localparam logic [6:0] V_OE1A = 7'b001_0010;
  localparam logic [6:0] V_OE2  = 7'b000_0001;
  localparam logic [6:0] V_OE2A = 7'b010_0001;

  logic [6:0] w_vec, w_nvec;
  assign w_vec  = {ld_ack, rd_ack, lat_clear, lat_latch, lat_oe1, lat_oe2};
  assign w_nvec = {n_ld_ack, n_rd_ack, n_lat_clear, n_lat_latch, n_lat_oe1, n_lat_oe2};

  typedef struct {
    int         cyc;
    logic [6:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   b;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void expect_at(input int c, input logic [6:0] v);
    q.push_back('{c, v});
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic pulse(input logic ld, input logic [1:0] rd);
    ld_req = ld;
    rd_req = rd;
    @(negedge clk);
    ld_req = 1'b0;
    rd_req = '0;
  endtask

  task automatic npulse(input logic ld, input logic [1:0] rd);
    n_ld_req = ld;
    n_rd_req = rd;
    @(negedge clk);
    n_ld_req = 1'b0;
    n_rd_req = '0;
  endtask

  task automatic goto(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  // Monitor: invariants every cycle; any non-idle control vector must match the queue head.
  always @(negedge clk) begin
    exp_t e;
    checks++;
    if ((lat_oe1 && lat_oe2) || ((lat_clear || lat_latch) && (lat_oe1 || lat_oe2)) ||
        (lat_clear && lat_latch)) begin
      errors++;
      $display("FAIL invariant: controls 0x%0h at cycle %0d", w_vec, cyc);
    end
    if (w_vec != '0) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got 0x%0h at cycle %0d, expected nothing", w_vec, cyc);
      end else begin
        e = q.pop_front();
        if (e.cyc != cyc || e.v != w_vec) begin
          errors++;
          $display("FAIL sb_output: got 0x%0h at cycle %0d expected 0x%0h at cycle %0d",
                   w_vec, cyc, e.v, e.cyc);
        end
      end
    end
  end

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_controls", 32'(w_vec), 32'h0);
    chk("reset_busy_valid", {30'd0, busy, valid}, 32'h0);
    chk("reset_nc_controls", 32'(w_nvec), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("release_busy_valid", {30'd0, busy, valid}, 32'h0);

    // Load with clear first
    b = cyc + 1;
    expect_at(b, V_CLR);
    expect_at(b + 1, V_LAT);
    pulse(1'b1, 2'b00);
    chk("load_valid_early", 32'(valid), 32'h0);
    goto(b + 2);
    chk("load_busy_valid", {30'd0, busy, valid}, 32'h1);

    // Single read on bus1
    b = cyc + 1;
    expect_at(b, V_OE1);
    expect_at(b + 1, V_OE1A);
    pulse(1'b0, 2'b01);
    goto(b + 2);
    chk("read1_turn_busy", 32'(busy), 32'h1);
    goto(b + 3);
    chk("read1_idle_busy", 32'(busy), 32'h0);

    // Reset during the first drive cycle
    b = cyc + 1;
    expect_at(b, V_OE1);
    pulse(1'b0, 2'b01);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_oe1", 32'(lat_oe1), 32'h0);
    chk("midreset_controls", 32'(w_vec), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    chk("midreset_busy_valid", {30'd0, busy, valid}, 32'h0);
    repeat (4) @(negedge clk);
    chk("midreset_no_pending", 32'(busy), 32'h0);
    chk("midreset_sb_empty", 32'(q.size()), 32'h0);

    // Simultaneous reads, twice: bus1 leads both times
    for (int r = 0; r < 2; r++) begin
      b = cyc + 1;
      expect_at(b, V_OE1);
      expect_at(b + 1, V_OE1A);
      expect_at(b + 3, V_OE2);
      expect_at(b + 4, V_OE2A);
      pulse(1'b0, 2'b11);
      goto(b + 2);
      chk("rr_turn_busy", 32'(busy), 32'h1);
      goto(b + 6);
      chk("rr_idle_busy", 32'(busy), 32'h0);
    end

    // Load and bus2 read together: load first, drive starts in cycle 3
    b = cyc + 1;
    expect_at(b, V_CLR);
    expect_at(b + 1, V_LAT);
    expect_at(b + 2, V_OE2);
    expect_at(b + 3, V_OE2A);
    pulse(1'b1, 2'b10);
    goto(b + 5);
    chk("ldrd_idle_busy", 32'(busy), 32'h0);

    // Load arriving during DRV2 waits for the turnaround
    b = cyc + 1;
    expect_at(b, V_OE2);
    expect_at(b + 1, V_OE2A);
    expect_at(b + 3, V_CLR);
    expect_at(b + 4, V_LAT);
    pulse(1'b0, 2'b10);
    pulse(1'b1, 2'b00);
    goto(b + 2);
    chk("deferred_turn_busy", 32'(busy), 32'h1);
    goto(b + 5);
    chk("deferred_idle_busy", 32'(busy), 32'h0);

    // No clear, no turnaround, single-cycle drive
    b = cyc + 1;
    npulse(1'b1, 2'b00);
    chk("nc_load_latch", 32'(w_nvec), 32'(V_LAT));
    goto(b + 1);
    chk("nc_load_busy_valid", {30'd0, n_busy, n_valid}, 32'h1);
    b = cyc + 1;
    npulse(1'b0, 2'b11);
    chk("nc_rd_bus1", 32'(w_nvec), 32'(V_OE1A));
    goto(b + 1);
    chk("nc_rd_bus2", 32'(w_nvec), 32'(V_OE2A));
    goto(b + 2);
    chk("nc_rd_idle", {25'd0, w_nvec}, {25'd0, 7'd0});
    chk("nc_rd_busy", 32'(n_busy), 32'h0);

    repeat (4) @(negedge clk);
    chk("sb_drained", 32'(q.size()), 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got cycle %0d expected completion", cyc);
    $fatal(1, "timeout");
  end

endmodule
